// File: rtl/watch_set_controller.sv
// Time-set sequencer for the watch: field select, inc/dec strobes, blink and hold.
// Optional hold-to-repeat strobes are built when WATCH_SET_AUTO_REPEAT_EN is defined.
module watch_set_controller #(
    parameter int TIMEOUT_T = 5000,
    parameter int BLINK_T   = 250,
    parameter int RPT_DLY_T = 500,
    parameter int RPT_PER_T = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_C,
    input  logic       btn_U,
    input  logic       btn_D,
    output logic [1:0] edit_field,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       blink,
    output logic       time_hold
);

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_e;

    localparam int TO_W = $clog2(TIMEOUT_T);
    localparam int BL_W = $clog2(BLINK_T);

    if (TIMEOUT_T < 2 || BLINK_T < 2 || RPT_DLY_T < 1 || RPT_PER_T < 1) begin : g_bad_param
        $error("watch_set_controller: counter parameters out of range");
    end

    state_e          state_q, state_d;
    logic            btn_c_q, btn_u_q, btn_d_q, armed_q;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
    logic            blink_q, blink_d;
    logic            inc_q, inc_d;
    logic            dec_q, dec_d;
    logic            hold_q, hold_d;

    logic rise_c, rise_u, rise_d;
    logic in_edit, key_up, key_dn;
    logic rpt_inc, rpt_dec;

    // armed_q masks the first cycle after reset so a button held through reset is not an edge.
    assign rise_c  = armed_q & btn_C & ~btn_c_q;
    assign rise_u  = armed_q & btn_U & ~btn_u_q;
    assign rise_d  = armed_q & btn_D & ~btn_d_q;
    assign in_edit = (state_q != NORMAL);
    assign key_up  = in_edit & rise_u & ~rise_d & ~rise_c;
    assign key_dn  = in_edit & rise_d & ~rise_u & ~rise_c;

`ifdef WATCH_SET_AUTO_REPEAT_EN
    localparam int RPT_MAX = (RPT_DLY_T > RPT_PER_T) ? RPT_DLY_T : RPT_PER_T;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    logic             rpt_act_q, rpt_act_d;
    logic             rpt_up_q, rpt_up_d;
    logic             rpt_per_q, rpt_per_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_fire, rpt_stop;

    always_comb begin
        rpt_act_d = rpt_act_q;
        rpt_up_d  = rpt_up_q;
        rpt_per_d = rpt_per_q;
        rpt_cnt_d = rpt_cnt_q;
        rpt_fire  = 1'b0;
        rpt_stop  = !in_edit || rise_c ||
                    (rpt_up_q ? (!btn_U || btn_D) : (!btn_D || btn_U));
        if (key_up && !btn_D) begin
            rpt_act_d = 1'b1;
            rpt_up_d  = 1'b1;
            rpt_per_d = 1'b0;
            rpt_cnt_d = '0;
        end else if (key_dn && !btn_U) begin
            rpt_act_d = 1'b1;
            rpt_up_d  = 1'b0;
            rpt_per_d = 1'b0;
            rpt_cnt_d = '0;
        end else if (rpt_act_q) begin
            if (rpt_stop) begin
                rpt_act_d = 1'b0;
            end else if (tick) begin
                if (!rpt_per_q && rpt_cnt_q == RPT_W'(RPT_DLY_T - 1)) begin
                    rpt_fire  = 1'b1;
                    rpt_per_d = 1'b1;
                    rpt_cnt_d = '0;
                end else if (rpt_per_q && rpt_cnt_q == RPT_W'(RPT_PER_T - 1)) begin
                    rpt_fire  = 1'b1;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_act_q <= 1'b0;
            rpt_up_q  <= 1'b0;
            rpt_per_q <= 1'b0;
            rpt_cnt_q <= '0;
        end else begin
            rpt_act_q <= rpt_act_d;
            rpt_up_q  <= rpt_up_d;
            rpt_per_q <= rpt_per_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    assign rpt_inc = rpt_fire & rpt_up_q;
    assign rpt_dec = rpt_fire & ~rpt_up_q;
`else
    assign rpt_inc = 1'b0;
    assign rpt_dec = 1'b0;
`endif

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        bl_cnt_d = bl_cnt_q;
        blink_d  = blink_q;
        inc_d    = key_up | rpt_inc;
        dec_d    = key_dn | rpt_dec;

        if (rise_c) begin
            unique case (state_q)
                NORMAL:   state_d = SET_HOUR;
                SET_HOUR: state_d = SET_MIN;
                SET_MIN:  state_d = SET_SEC;
                SET_SEC:  state_d = NORMAL;
                default:  state_d = NORMAL;
            endcase
        end

        // Any activity beats an expiring timeout in the same cycle.
        if (rise_c || rise_u || rise_d || inc_d || dec_d || !in_edit) begin
            to_cnt_d = '0;
        end else if (tick) begin
            if (to_cnt_q == TO_W'(TIMEOUT_T - 1)) begin
                to_cnt_d = '0;
                state_d  = NORMAL;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end

        if (state_d == NORMAL) begin
            blink_d  = 1'b0;
            bl_cnt_d = '0;
        end else if (state_d != state_q || inc_d || dec_d) begin
            blink_d  = 1'b1;
            bl_cnt_d = '0;
        end else if (tick) begin
            if (bl_cnt_q == BL_W'(BLINK_T - 1)) begin
                blink_d  = ~blink_q;
                bl_cnt_d = '0;
            end else begin
                bl_cnt_d = bl_cnt_q + BL_W'(1);
            end
        end

        hold_d = (state_d == SET_SEC);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= NORMAL;
            btn_c_q  <= 1'b0;
            btn_u_q  <= 1'b0;
            btn_d_q  <= 1'b0;
            armed_q  <= 1'b0;
            to_cnt_q <= '0;
            bl_cnt_q <= '0;
            blink_q  <= 1'b0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            btn_c_q  <= btn_C;
            btn_u_q  <= btn_U;
            btn_d_q  <= btn_D;
            armed_q  <= 1'b1;
            to_cnt_q <= to_cnt_d;
            bl_cnt_q <= bl_cnt_d;
            blink_q  <= blink_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            hold_q   <= hold_d;
        end
    end

    assign edit_field = state_q;
    assign inc_pulse  = inc_q;
    assign dec_pulse  = dec_q;
    assign blink      = blink_q;
    assign time_hold  = hold_q;

endmodule
